// File: rtl/interfaz_round_robin_tester_pkg.sv
// Shared definitions for the egress round-robin scheduler and its equivalence wrapper.
// Policy encodings and helpers that size the selector and weight fields.
package interfaz_round_robin_tester_pkg;

  typedef enum logic [1:0] {
    RR_OFF      = 2'b00,
    RR_PLAIN    = 2'b01,
    RR_WEIGHTED = 2'b10,
    RR_TABLE    = 2'b11
  } rr_policy_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned weight_width(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/round_robin_scheduler.sv
// Egress queue scheduler core: plain RR, weighted RR and table-driven arbitration.
// One registered grant decision per enabled clock.
module round_robin_scheduler
  import interfaz_round_robin_tester_pkg::*;
#(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned MAX_WEIGHT     = 64,
  parameter int unsigned TABLE_SIZE     = 8,
  localparam int unsigned S             = sel_width(QUEUE_QUANTITY),
  localparam int unsigned W             = weight_width(MAX_WEIGHT),
  localparam int unsigned IW            = sel_width(TABLE_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_enb,
  input  logic [S-1:0]               i_policy,
  input  logic [QUEUE_QUANTITY*W-1:0] i_pesos,
  input  logic [TABLE_SIZE*W-1:0]    i_pesos_arb,
  input  logic [TABLE_SIZE*S-1:0]    i_selecciones,
  input  logic [QUEUE_QUANTITY-1:0]  i_buf_empty,
  output logic [S-1:0]               o_selector,
  output logic                       o_selector_enb
);

  logic [S-1:0]  r_ptr, r_ptr_d;
  logic [W-1:0]  r_cnt, r_cnt_d;
  logic [IW-1:0] r_idx, r_idx_d;
  rr_policy_e    r_prev, r_prev_d;
  logic [S-1:0]  r_sel, r_sel_d;
  logic          r_sel_enb, r_sel_enb_d;

  rr_policy_e    w_pol;
  logic          w_chg;
  logic [W-1:0]  w_cnt_eff, w_cnt_inc, w_ptr_w, w_t_w;
  logic [IW-1:0] w_idx_eff, w_idx_next;
  logic [S-1:0]  w_t_sel;
  logic          w_rr_found, w_wrr_found, w_stay;
  logic [S-1:0]  w_rr_q, w_wrr_q;

  assign w_pol      = rr_policy_e'(i_policy[1:0]);
  assign w_chg      = (w_pol != r_prev);
  assign w_cnt_eff  = w_chg ? '0 : r_cnt;
  assign w_idx_eff  = w_chg ? '0 : r_idx;
  assign w_cnt_inc  = w_cnt_eff + 1'b1;
  assign w_ptr_w    = i_pesos[r_ptr*W +: W];
  assign w_t_sel    = i_selecciones[w_idx_eff*S +: S];
  assign w_t_w      = i_pesos_arb[w_idx_eff*W +: W];
  assign w_idx_next = (w_idx_eff == IW'(TABLE_SIZE - 1)) ? '0 : w_idx_eff + 1'b1;
  // cnt == 0 means no burst is open, so the weighted policy must look past ptr.
  assign w_stay     = (w_cnt_eff != '0) && !i_buf_empty[r_ptr] && (w_cnt_eff < w_ptr_w);

  // Walk from the farthest offset to the nearest so the nearest candidate wins.
  always_comb begin
    int unsigned v_q;
    v_q         = 0;
    w_rr_found  = 1'b0;
    w_rr_q      = r_ptr;
    w_wrr_found = 1'b0;
    w_wrr_q     = r_ptr;
    for (int unsigned k = QUEUE_QUANTITY; k > 0; k--) begin
      v_q = (32'(r_ptr) + k) % QUEUE_QUANTITY;
      if (!i_buf_empty[v_q]) begin
        w_rr_found = 1'b1;
        w_rr_q     = S'(v_q);
        if (i_pesos[v_q*W +: W] != '0) begin
          w_wrr_found = 1'b1;
          w_wrr_q     = S'(v_q);
        end
      end
    end
  end

  always_comb begin
    r_ptr_d     = r_ptr;
    r_cnt_d     = r_cnt;
    r_idx_d     = r_idx;
    r_prev_d    = r_prev;
    r_sel_d     = r_sel;
    r_sel_enb_d = 1'b0;
    if (i_enb) begin
      r_prev_d = w_pol;
      r_cnt_d  = w_cnt_eff;
      r_idx_d  = w_idx_eff;
      case (w_pol)
        RR_PLAIN: begin
          if (w_rr_found) begin
            r_ptr_d     = w_rr_q;
            r_sel_d     = w_rr_q;
            r_sel_enb_d = 1'b1;
          end
        end
        RR_WEIGHTED: begin
          if (w_stay) begin
            r_cnt_d     = w_cnt_inc;
            r_sel_d     = r_ptr;
            r_sel_enb_d = 1'b1;
          end else if (w_wrr_found) begin
            r_ptr_d     = w_wrr_q;
            r_cnt_d     = W'(1);
            r_sel_d     = w_wrr_q;
            r_sel_enb_d = 1'b1;
          end
        end
        RR_TABLE: begin
          if ((w_t_w == '0) || i_buf_empty[w_t_sel]) begin
            r_idx_d = w_idx_next;
            r_cnt_d = '0;
          end else begin
            r_sel_d     = w_t_sel;
            r_sel_enb_d = 1'b1;
            if (w_cnt_inc >= w_t_w) begin
              r_idx_d = w_idx_next;
              r_cnt_d = '0;
            end else begin
              r_cnt_d = w_cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= S'(QUEUE_QUANTITY - 1);
      r_cnt     <= '0;
      r_idx     <= '0;
      r_prev    <= RR_OFF;
      r_sel     <= '0;
      r_sel_enb <= 1'b0;
    end else begin
      r_ptr     <= r_ptr_d;
      r_cnt     <= r_cnt_d;
      r_idx     <= r_idx_d;
      r_prev    <= r_prev_d;
      r_sel     <= r_sel_d;
      r_sel_enb <= r_sel_enb_d;
    end
  end

  assign o_selector     = r_sel;
  assign o_selector_enb = r_sel_enb;

endmodule

// File: rtl/round_robin_scheduler_sint.sv
// Behavioural stand-in for the synthesized gate-level scheduler; the netlist file provides
// this module in gate-level runs with the same ports and parameters.
module round_robin_scheduler_sint
  import interfaz_round_robin_tester_pkg::*;
#(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned MAX_WEIGHT     = 64,
  parameter int unsigned TABLE_SIZE     = 8,
  localparam int unsigned S             = sel_width(QUEUE_QUANTITY),
  localparam int unsigned W             = weight_width(MAX_WEIGHT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_enb,
  input  logic [S-1:0]               i_policy,
  input  logic [QUEUE_QUANTITY*W-1:0] i_pesos,
  input  logic [TABLE_SIZE*W-1:0]    i_pesos_arb,
  input  logic [TABLE_SIZE*S-1:0]    i_selecciones,
  input  logic [QUEUE_QUANTITY-1:0]  i_buf_empty,
  output logic [S-1:0]               o_selector,
  output logic                       o_selector_enb
);

  round_robin_scheduler #(
    .QUEUE_QUANTITY(QUEUE_QUANTITY),
    .MAX_WEIGHT    (MAX_WEIGHT),
    .TABLE_SIZE    (TABLE_SIZE)
  ) u_core (
    .clk           (clk),
    .rst           (rst),
    .i_enb         (i_enb),
    .i_policy      (i_policy),
    .i_pesos       (i_pesos),
    .i_pesos_arb   (i_pesos_arb),
    .i_selecciones (i_selecciones),
    .i_buf_empty   (i_buf_empty),
    .o_selector    (o_selector),
    .o_selector_enb(o_selector_enb)
  );

endmodule

// File: rtl/interfaz_round_robin_tester.sv
// Equivalence wrapper: drives the same inputs into the RTL and netlist schedulers
// and exposes both result pairs side by side.
module interfaz_round_robin_tester
  import interfaz_round_robin_tester_pkg::*;
#(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned MAX_WEIGHT     = 64,
  parameter int unsigned BUF_WIDTH      = 3,
  parameter int unsigned TABLE_SIZE     = 8,
  localparam int unsigned S             = sel_width(QUEUE_QUANTITY),
  localparam int unsigned W             = weight_width(MAX_WEIGHT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enb,
  input  logic [S-1:0]               seleccion_roundRobin,
  input  logic [QUEUE_QUANTITY*W-1:0] pesos,
  input  logic [TABLE_SIZE*W-1:0]    pesosArbitraje,
  input  logic [TABLE_SIZE*S-1:0]    selecciones,
  input  logic [QUEUE_QUANTITY-1:0]  buf_empty,
  output logic [S-1:0]               selector,
  output logic                       selector_enb,
  output logic [S-1:0]               sint_selector,
  output logic                       sint_selector_enb
);

  // DATA_BITS and BUF_WIDTH only keep the parameter list aligned with the rest of the queue.
  if ((DATA_BITS == 0) || (BUF_WIDTH == 0)) begin : g_unused_cfg
  end

  round_robin_scheduler #(
    .QUEUE_QUANTITY(QUEUE_QUANTITY),
    .MAX_WEIGHT    (MAX_WEIGHT),
    .TABLE_SIZE    (TABLE_SIZE)
  ) u_rtl (
    .clk           (clk),
    .rst           (rst),
    .i_enb         (enb),
    .i_policy      (seleccion_roundRobin),
    .i_pesos       (pesos),
    .i_pesos_arb   (pesosArbitraje),
    .i_selecciones (selecciones),
    .i_buf_empty   (buf_empty),
    .o_selector    (selector),
    .o_selector_enb(selector_enb)
  );

  round_robin_scheduler_sint #(
    .QUEUE_QUANTITY(QUEUE_QUANTITY),
    .MAX_WEIGHT    (MAX_WEIGHT),
    .TABLE_SIZE    (TABLE_SIZE)
  ) u_sint (
    .clk           (clk),
    .rst           (rst),
    .i_enb         (enb),
    .i_policy      (seleccion_roundRobin),
    .i_pesos       (pesos),
    .i_pesos_arb   (pesosArbitraje),
    .i_selecciones (selecciones),
    .i_buf_empty   (buf_empty),
    .o_selector    (sint_selector),
    .o_selector_enb(sint_selector_enb)
  );

endmodule

// File: tb/tb_interfaz_round_robin_tester.sv
// Bench for the scheduler equivalence wrapper: directed policy scenarios with literal
// grant sequences, plus a per-cycle comparison against a behavioural scheduling model.
module tb_interfaz_round_robin_tester;

  localparam int NQ = 4;
  localparam int NT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enb = 1'b0;
  logic [1:0]  pol = 2'b00;
  logic [23:0] pesos = '0;
  logic [47:0] pesos_arb = '0;
  logic [15:0] sels = '0;
  logic [3:0]  be = '0;
  logic [1:0]  selector, sint_selector;
  logic        selector_enb, sint_selector_enb;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  int m_ptr  = NQ - 1;
  int m_cnt  = 0;
  int m_idx  = 0;
  int m_prev = 0;
  int m_sel  = 0;
  bit m_enb  = 1'b0;

  always #5 clk = ~clk;

  interfaz_round_robin_tester dut (
    .clk                 (clk),
    .rst                 (rst),
    .enb                 (enb),
    .seleccion_roundRobin(pol),
    .pesos               (pesos),
    .pesosArbitraje      (pesos_arb),
    .selecciones         (sels),
    .buf_empty           (be),
    .selector            (selector),
    .selector_enb        (selector_enb),
    .sint_selector       (sint_selector),
    .sint_selector_enb   (sint_selector_enb)
  );

  function automatic int qweight(input int q);
    return int'(pesos[q*6 +: 6]);
  endfunction

  function automatic int tweight(input int e);
    return int'(pesos_arb[e*6 +: 6]);
  endfunction

  function automatic int tqueue(input int e);
    return int'(sels[e*2 +: 2]);
  endfunction

  // Next non-empty queue after m_ptr in circular order; -1 when none qualifies.
  function automatic int next_queue(input bit need_weight);
    for (int k = 1; k <= NQ; k++) begin
      int q;
      q = (m_ptr + k) % NQ;
      if (!be[q] && (!need_weight || qweight(q) != 0)) return q;
    end
    return -1;
  endfunction

  task automatic model_step();
    int g;
    if (!enb) begin
      m_enb = 1'b0;
      return;
    end
    if (int'(pol) != m_prev) begin
      m_cnt = 0;
      m_idx = 0;
    end
    m_prev = int'(pol);
    m_enb  = 1'b0;
    case (pol)
      2'b01: begin
        g = next_queue(1'b0);
        if (g >= 0) begin
          m_ptr = g; m_sel = g; m_enb = 1'b1;
        end
      end
      2'b10: begin
        if (m_cnt > 0 && !be[m_ptr] && m_cnt < qweight(m_ptr)) begin
          m_cnt++; m_sel = m_ptr; m_enb = 1'b1;
        end else begin
          g = next_queue(1'b1);
          if (g >= 0) begin
            m_ptr = g; m_cnt = 1; m_sel = g; m_enb = 1'b1;
          end
        end
      end
      2'b11: begin
        if (tweight(m_idx) == 0 || be[tqueue(m_idx)]) begin
          m_idx = (m_idx + 1) % NT; m_cnt = 0;
        end else begin
          m_sel = tqueue(m_idx); m_enb = 1'b1; m_cnt++;
          if (m_cnt >= tweight(m_idx)) begin
            m_idx = (m_idx + 1) % NT; m_cnt = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_ptr = NQ - 1; m_cnt = 0; m_idx = 0; m_prev = 0; m_sel = 0; m_enb = 1'b0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      n_tests++;
      if (selector_enb !== m_enb || int'(selector) != m_sel) begin
        n_fail++;
        $display("FAIL model @%0t: got sel=%0d enb=%0b, expected sel=%0d enb=%0b",
                 $time, selector, selector_enb, m_sel, m_enb);
      end
      n_tests++;
      if (sint_selector !== selector || sint_selector_enb !== selector_enb) begin
        n_fail++;
        $display("FAIL equiv @%0t: sint sel=%0d enb=%0b, rtl sel=%0d enb=%0b",
                 $time, sint_selector, sint_selector_enb, selector, selector_enb);
      end
    end
  end

  task automatic expect_grant(input string nm, input int q);
    @(negedge clk);
    n_tests++;
    if (selector_enb !== 1'b1 || int'(selector) != q) begin
      n_fail++;
      $display("FAIL %s @%0t: got sel=%0d enb=%0b, expected sel=%0d enb=1",
               nm, $time, selector, selector_enb, q);
    end
  endtask

  task automatic expect_run(input string nm, input int q, input int n);
    for (int i = 0; i < n; i++) expect_grant(nm, q);
  endtask

  task automatic expect_idle(input string nm, input int held);
    @(negedge clk);
    n_tests++;
    if (selector_enb !== 1'b0 || int'(selector) != held) begin
      n_fail++;
      $display("FAIL %s @%0t: got sel=%0d enb=%0b, expected sel=%0d enb=0",
               nm, $time, selector, selector_enb, held);
    end
  endtask

  task automatic expect_zero_now(input string nm);
    n_tests++;
    if (selector !== 2'd0 || selector_enb !== 1'b0 ||
        sint_selector !== 2'd0 || sint_selector_enb !== 1'b0) begin
      n_fail++;
      $display("FAIL %s @%0t: got rtl=%0d/%0b sint=%0d/%0b, expected 0/0 on both",
               nm, $time, selector, selector_enb, sint_selector, sint_selector_enb);
    end
  endtask

  int wr[4]  = '{6, 5, 7, 2};
  int tq[8]  = '{3, 1, 2, 0, 1, 2, 0, 2};
  int tw[8]  = '{6, 11, 11, 15, 3, 5, 5, 14};

  initial begin
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    expect_zero_now("reset");

    rst = 1'b1; enb = 1'b1; pol = 2'b01; be = 4'b0000;
    for (int i = 0; i < 8; i++) expect_grant("rr_all", i % 4);
    be = 4'b0101;
    for (int i = 0; i < 4; i++) expect_grant("rr_0101", (i % 2 == 0) ? 1 : 3);
    be = 4'b1111;
    repeat (3) expect_idle("rr_empty", 3);

    pol = 2'b10; be = 4'b0000;
    for (int q = 0; q < NQ; q++) pesos[q*6 +: 6] = 6'(wr[q]);
    for (int q = 0; q < NQ; q++) expect_run("wrr_round", q, wr[q]);
    expect_run("wrr_pre_hold", 0, 3);
    enb = 1'b0;
    repeat (10) expect_idle("wrr_hold", 0);
    enb = 1'b1;
    expect_run("wrr_resume", 0, 3);
    expect_run("wrr_next", 1, 5);

    pol = 2'b11;
    for (int e = 0; e < NT; e++) begin
      sels[e*2 +: 2]      = 2'(tq[e]);
      pesos_arb[e*6 +: 6] = 6'(tw[e]);
    end
    for (int e = 0; e < NT; e++) expect_run("tbl_run", tq[e], tw[e]);
    expect_run("tbl_wrap", 3, 2);

    #3 rst = 1'b0;
    #1 expect_zero_now("rst_async");
    expect_idle("rst_hold", 0);
    rst = 1'b1; pol = 2'b01; be = 4'b0000;
    expect_grant("rst_first", 0);

    pol = 2'b00;
    expect_idle("pol_off", 0);
    pol = 2'b11; be = 4'b1000;
    expect_idle("tbl_skip", 0);
    expect_run("tbl_after_skip", 1, 11);
    expect_run("tbl_after_skip", 2, 11);
    expect_run("tbl_after_skip", 0, 2);

    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      be  = 4'($urandom);
      enb = ($urandom_range(0, 7) != 0);
      if (c % 37 == 0) pol = 2'($urandom);
      if (c % 53 == 0) begin
        for (int q = 0; q < NQ; q++)
          pesos[q*6 +: 6] = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 9));
      end
      if (c % 211 == 0) begin
        for (int e = 0; e < NT; e++) begin
          sels[e*2 +: 2]      = 2'($urandom);
          pesos_arb[e*6 +: 6] = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 12));
        end
      end
    end
    @(negedge clk);
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
